// File: rtl/board_data_collector.sv
// Board data collector: strobe edge detection, slot tagging and a word FIFO
// that a host drains one word per read request.
module board_data_collector #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          FRC_IN,
    input  logic          _RES_HARD,
    input  logic          ENABLE,
    input  logic          CLK_BUFER_IN,
    input  logic          WRITE_BUFER_IN,
    input  logic [3:0]    COUNT_BOARD_IN,
    input  logic [7:0]    DATA_IN,
    input  logic          RD_REQ,
    output logic [15:0]   DATA_OUT,
    output logic          DATA_VALID,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT_WORDS,
    output logic          OVERFLOW,
    output logic [1:0]    STATE
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            clk_buf_q, wr_buf_q;
    logic [1:0]      slot_q, slot_d;
    logic            pend_q, pend_d;
    logic [15:0]     pend_word_q, pend_word_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d, full_q, full_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic [15:0]     mem [DEPTH];

    logic            clk_edge_c, wr_edge_c, capture_c;
    logic            rd_en_c, drop_c, wr_en_c;

    assign clk_edge_c = CLK_BUFER_IN & ~clk_buf_q;
    assign wr_edge_c  = WRITE_BUFER_IN & ~wr_buf_q;
    assign capture_c  = (state_q == ST_COLLECT) & clk_edge_c;
    assign rd_en_c    = RD_REQ & ~empty_q;
    assign drop_c     = pend_q & full_q & ~rd_en_c;
    assign wr_en_c    = pend_q & ~drop_c;

    // Next-state logic for the FSM, slot counter, capture stage and FIFO bookkeeping
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        pend_d      = capture_c;
        pend_word_d = pend_word_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        dout_d      = dout_q;
        dvalid_d    = 1'b0;

        unique case (state_q)
            ST_IDLE:    if (ENABLE) state_d = ST_SYNC;
            ST_SYNC:    if (!ENABLE) state_d = ST_IDLE;
                        else if (wr_edge_c) state_d = ST_COLLECT;
            ST_COLLECT: if (!ENABLE) state_d = ST_IDLE;
                        else if (drop_c) state_d = ST_HALT;
            ST_HALT:    if (!ENABLE) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Byte is tagged with the current slot; a block strobe clears it afterwards
        if (capture_c) begin
            pend_word_d = {COUNT_BOARD_IN, slot_q, 2'b00, DATA_IN};
            slot_d      = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
        end
        if (wr_edge_c) slot_d = 2'd0;

        if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem[rd_ptr_q];
            dvalid_d = 1'b1;
        end

        unique case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (state_q == ST_IDLE && ENABLE) ovf_d = 1'b0;
        if (drop_c) ovf_d = 1'b1;

        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge FRC_IN) begin
        if (!_RES_HARD) begin
            state_q     <= ST_IDLE;
            clk_buf_q   <= 1'b0;
            wr_buf_q    <= 1'b0;
            slot_q      <= 2'd0;
            pend_q      <= 1'b0;
            pend_word_q <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dout_q      <= 16'd0;
            dvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_buf_q   <= CLK_BUFER_IN;
            wr_buf_q    <= WRITE_BUFER_IN;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
        end
    end

    // FIFO storage; a reset cycle suppresses the pending write
    always_ff @(posedge FRC_IN) begin
        if (_RES_HARD && wr_en_c) mem[wr_ptr_q] <= pend_word_q;
    end

    assign DATA_OUT    = dout_q;
    assign DATA_VALID  = dvalid_q;
    assign EMPTY       = empty_q;
    assign FULL        = full_q;
    assign COUNT_WORDS = count_q;
    assign OVERFLOW    = ovf_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_board_data_collector.sv
// Bench for board_data_collector: directed and randomized strobes against a
// queue-based model of the collector's behaviour.
module tb_board_data_collector;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          FRC_IN = 1'b0;
    logic          _RES_HARD, ENABLE, CLK_BUFER_IN, WRITE_BUFER_IN, RD_REQ;
    logic [3:0]    COUNT_BOARD_IN;
    logic [7:0]    DATA_IN;
    logic [15:0]   DATA_OUT;
    logic          DATA_VALID, EMPTY, FULL, OVERFLOW;
    logic [AW:0]   COUNT_WORDS;
    logic [1:0]    STATE;

    board_data_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .FRC_IN(FRC_IN), ._RES_HARD(_RES_HARD), .ENABLE(ENABLE),
        .CLK_BUFER_IN(CLK_BUFER_IN), .WRITE_BUFER_IN(WRITE_BUFER_IN),
        .COUNT_BOARD_IN(COUNT_BOARD_IN), .DATA_IN(DATA_IN), .RD_REQ(RD_REQ),
        .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .EMPTY(EMPTY), .FULL(FULL),
        .COUNT_WORDS(COUNT_WORDS), .OVERFLOW(OVERFLOW), .STATE(STATE)
    );

    always #5 FRC_IN = ~FRC_IN;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 waiting for block start, 2 collecting, 3 halted
    int          m_state;
    int          m_slot;
    bit          m_ovf;
    logic [15:0] m_q[$];
    logic [15:0] m_last;

    task automatic tick();
        @(posedge FRC_IN);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(COUNT_WORDS), 32'(m_q.size()));
        check({tag, "_empty"}, 32'(EMPTY), 32'(m_q.size() == 0));
        check({tag, "_full"},  32'(FULL),  32'(m_q.size() == DEPTH));
        check({tag, "_ovf"},   32'(OVERFLOW), 32'(m_ovf));
        check({tag, "_state"}, 32'(STATE), 32'(m_state));
    endtask

    // Model of one captured byte; returns the word as the spec composes it
    task automatic model_byte(input logic [7:0] d, input logic [3:0] b);
        logic [15:0] w;
        if (m_state != 2) return;
        w = 16'(b) << 12 | 16'(m_slot) << 10 | 16'(d);
        if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
            m_state = 3;
        end else begin
            m_q.push_back(w);
        end
        m_slot = (m_slot + 1) % 3;
    endtask

    task automatic model_block();
        m_slot = 0;
        if (m_state == 1) m_state = 2;
    endtask

    task automatic byte_strobe(input logic [7:0] d, input logic [3:0] b);
        CLK_BUFER_IN = 1'b1; DATA_IN = d; COUNT_BOARD_IN = b;
        tick();
        CLK_BUFER_IN = 1'b0; DATA_IN = 8'($urandom); COUNT_BOARD_IN = 4'($urandom);
        tick();
        model_byte(d, b);
    endtask

    task automatic block_strobe();
        WRITE_BUFER_IN = 1'b1;
        tick();
        WRITE_BUFER_IN = 1'b0;
        tick();
        model_block();
    endtask

    task automatic both_strobe(input logic [7:0] d, input logic [3:0] b);
        CLK_BUFER_IN = 1'b1; WRITE_BUFER_IN = 1'b1; DATA_IN = d; COUNT_BOARD_IN = b;
        tick();
        CLK_BUFER_IN = 1'b0; WRITE_BUFER_IN = 1'b0;
        tick();
        model_byte(d, b);
        model_block();
    endtask

    task automatic read_word(input string tag);
        logic [15:0] exp;
        RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        if (m_q.size() != 0) begin
            exp = m_q.pop_front();
            check({tag, "_valid"}, 32'(DATA_VALID), 32'd1);
            check({tag, "_data"},  32'(DATA_OUT), 32'(exp));
            m_last = exp;
        end else begin
            check({tag, "_novalid"}, 32'(DATA_VALID), 32'd0);
            check({tag, "_hold"},    32'(DATA_OUT), 32'(m_last));
        end
        tick();
        check({tag, "_pulse"}, 32'(DATA_VALID), 32'd0);
        check({tag, "_keep"},  32'(DATA_OUT), 32'(m_last));
    endtask

    task automatic set_enable(input logic v);
        ENABLE = v;
        tick();
        if (v && m_state == 0) begin
            m_state = 1;
            m_ovf = 1'b0;
        end else if (!v) begin
            m_state = 0;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_slot = 0; m_ovf = 1'b0; m_last = 16'd0;
        m_q.delete();
    endtask

    initial begin
        logic [7:0]  d;
        logic [3:0]  b;
        logic [15:0] exp;
        int          r;

        _RES_HARD = 1'b0; ENABLE = 1'b0; CLK_BUFER_IN = 1'b0; WRITE_BUFER_IN = 1'b0;
        RD_REQ = 1'b0; DATA_IN = 8'd0; COUNT_BOARD_IN = 4'd0;
        model_reset();
        tick(); tick();
        _RES_HARD = 1'b1;
        check_status("reset");
        check("reset_dout",   32'(DATA_OUT), 32'd0);
        check("reset_dvalid", 32'(DATA_VALID), 32'd0);

        // Byte strobes before the first block strobe are ignored
        set_enable(1'b1);
        check_status("sync_enter");
        for (int i = 0; i < 3; i++) byte_strobe(8'($urandom), 4'($urandom));
        check_status("sync_discard");

        // Basic capture
        block_strobe();
        check_status("collect_enter");
        byte_strobe(8'h11, 4'd5);
        byte_strobe(8'h22, 4'd5);
        byte_strobe(8'h33, 4'd5);
        check_status("basic");
        check("basic_w0", 32'(m_q[0]), 32'h5011);
        for (int i = 0; i < 3; i++) read_word("basic_rd");
        check_status("basic_drained");
        check("basic_last", 32'(DATA_OUT), 32'h5833);

        // Read while empty
        read_word("empty_rd");
        check_status("empty_rd");

        // Randomized mix of strobes and reads
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            d = 8'($urandom); b = 4'($urandom);
            if (r <= 5 && m_q.size() < DEPTH - 1) byte_strobe(d, b);
            else if (r == 6) block_strobe();
            else if (r == 7 && m_q.size() < DEPTH - 1) both_strobe(d, b);
            else read_word("rand_rd");
            check_status("rand");
        end
        while (m_q.size() != 0) read_word("rand_drain");
        check_status("rand_drained");

        // Overflow: 17 captures without reads
        block_strobe();
        for (int i = 0; i < DEPTH + 1; i++) byte_strobe(8'($urandom), 4'($urandom));
        check_status("ovf");
        check("ovf_state", 32'(STATE), 32'd3);
        byte_strobe(8'($urandom), 4'($urandom));
        check_status("halt_nowrite");
        for (int i = 0; i < DEPTH; i++) read_word("ovf_rd");
        read_word("ovf_17th_absent");
        check_status("ovf_drained");

        // Leaving HALT keeps OVERFLOW until re-enable
        set_enable(1'b0);
        check_status("halt_exit");
        set_enable(1'b1);
        check_status("reenable");

        // Write and read in the same cycle while full
        block_strobe();
        for (int i = 0; i < DEPTH; i++) byte_strobe(8'($urandom), 4'($urandom));
        check_status("full");
        d = 8'($urandom); b = 4'($urandom);
        CLK_BUFER_IN = 1'b1; DATA_IN = d; COUNT_BOARD_IN = b;
        tick();
        CLK_BUFER_IN = 1'b0; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        exp = m_q.pop_front();
        m_last = exp;
        model_byte(d, b);
        check("fullrw_valid", 32'(DATA_VALID), 32'd1);
        check("fullrw_data",  32'(DATA_OUT), 32'(exp));
        check_status("fullrw");
        tick();
        check("fullrw_pulse", 32'(DATA_VALID), 32'd0);

        // Reset while holding 5 words in COLLECT
        while (m_q.size() != 0) read_word("pre_reset_drain");
        for (int i = 0; i < 5; i++) byte_strobe(8'($urandom), 4'($urandom));
        check_status("pre_reset");
        _RES_HARD = 1'b0;
        tick();
        model_reset();
        check_status("hard_reset");
        check("hard_reset_dout", 32'(DATA_OUT), 32'd0);
        ENABLE = 1'b0; _RES_HARD = 1'b1;
        tick();
        check_status("post_reset");

        // Reset lands on the cycle of a pending write
        set_enable(1'b1);
        block_strobe();
        CLK_BUFER_IN = 1'b1; DATA_IN = 8'hA5; COUNT_BOARD_IN = 4'd3;
        tick();
        CLK_BUFER_IN = 1'b0; _RES_HARD = 1'b0;
        tick();
        model_reset();
        check_status("midwrite_reset");
        _RES_HARD = 1'b1; ENABLE = 1'b0;
        tick();
        check_status("midwrite_after");
        read_word("midwrite_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
